dreg_bank: RTL and testbench

Parametrised multi-entry data register bank; the next generation of the single-word load register. It holds DEPTH words of W bits with one addressed write port and two independent registered read ports. It adds write-first bypass, a per-entry written flag and a synchronous bank clear. It sits beside the datapath as a small general-purpose register file on the 50 MHz domain.

---
 rtl/dreg_pkg.sv | 15 +
 rtl/dreg_bank_entry.sv | 28 ++
 rtl/dreg_bank.sv | 97 +++++++++
 tb/tb_dreg_bank.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/dreg_pkg.sv
// rtl/dreg_pkg.sv - shared helpers for dreg_bank: byte-lane count, reset value, address range check
package dreg_pkg;

  localparam logic RESET_BIT = 1'b0;

  function automatic int byte_lanes(input int width);
    return width / 8;
  endfunction

  // DEPTH need not be a power of two, so the top address codes may be unused
  function automatic logic addr_in_range(input int addr, input int depth);
    return addr < depth;
  endfunction

endpackage

// File: rtl/dreg_bank_entry.sv
// rtl/dreg_bank_entry.sv - one W-bit word register with per-byte enable, async reset and sync clear
module dreg_bank_entry
  import dreg_pkg::*;
#(
  parameter int W = 16,
  localparam int NB = byte_lanes(W)
) (
  input  logic          clk50m,
  input  logic          rst_n,
  input  logic          clr,
  input  logic [NB-1:0] we,
  input  logic [W-1:0]  d,
  output logic [W-1:0]  q
);

  always_ff @(posedge clk50m or negedge rst_n) begin
    if (!rst_n) begin
      q <= {W{RESET_BIT}};
    end else if (clr) begin
      q <= {W{RESET_BIT}};
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (we[i]) q[8*i +: 8] <= d[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/dreg_bank.sv
// rtl/dreg_bank.sv - DEPTH x W register bank, one write port, two registered read ports with write-first bypass
// Optional byte-masked writes via DREG_BANK_BYTEMASK_EN.
module dreg_bank
  import dreg_pkg::*;
#(
  parameter int W = 16,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk50m,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic             clr,
  input  logic [AW-1:0]    waddr,
  input  logic [W-1:0]     d,
`ifdef DREG_BANK_BYTEMASK_EN
  input  logic [W/8-1:0]   be,
`endif
  input  logic [AW-1:0]    raddr_a,
  input  logic [AW-1:0]    raddr_b,
  output logic [W-1:0]     qa,
  output logic [W-1:0]     qb,
  output logic [DEPTH-1:0] written
);

  localparam int NB = byte_lanes(W);
  localparam logic [W-1:0] ZERO_WORD = {W{RESET_BIT}};

  logic [NB-1:0]    mask;
  logic             wr_ok;
  logic [W-1:0]     words [DEPTH];
  logic [W-1:0]     old_word;
  logic [W-1:0]     merged;
  logic [W-1:0]     rd_a;
  logic [W-1:0]     rd_b;
  logic [DEPTH-1:0] wr_hit;

`ifdef DREG_BANK_BYTEMASK_EN
  assign mask = be;
`else
  assign mask = '1;
`endif

  assign wr_ok = en && load && !clr && addr_in_range(32'(waddr), DEPTH);

  // Unmatched (out-of-range) addresses fall through to the zero default
  always_comb begin
    old_word = ZERO_WORD;
    rd_a     = ZERO_WORD;
    rd_b     = ZERO_WORD;
    wr_hit   = '0;
    for (int n = 0; n < DEPTH; n++) begin
      if (waddr == AW'(n)) begin
        old_word  = words[n];
        wr_hit[n] = wr_ok;
      end
      if (raddr_a == AW'(n)) rd_a = words[n];
      if (raddr_b == AW'(n)) rd_b = words[n];
    end
    merged = old_word;
    for (int i = 0; i < NB; i++) begin
      if (mask[i]) merged[8*i +: 8] = d[8*i +: 8];
    end
  end

  for (genvar n = 0; n < DEPTH; n++) begin : g_entry
    dreg_bank_entry #(.W(W)) u_entry (
      .clk50m (clk50m),
      .rst_n  (rst_n),
      .clr    (en && clr),
      .we     ({NB{wr_hit[n]}} & mask),
      .d      (d),
      .q      (words[n])
    );
  end

  // wr_ok implies waddr is in range, so a bypass hit never selects a phantom entry
  always_ff @(posedge clk50m or negedge rst_n) begin
    if (!rst_n) begin
      qa      <= ZERO_WORD;
      qb      <= ZERO_WORD;
      written <= '0;
    end else if (en) begin
      if (clr) begin
        qa      <= ZERO_WORD;
        qb      <= ZERO_WORD;
        written <= '0;
      end else begin
        qa      <= (wr_ok && (raddr_a == waddr)) ? merged : rd_a;
        qb      <= (wr_ok && (raddr_b == waddr)) ? merged : rd_b;
        written <= written | wr_hit;
      end
    end
  end

endmodule

// File: tb/tb_dreg_bank.sv
// tb/tb_dreg_bank.sv - scoreboard bench for dreg_bank against an array-based reference model
module tb_dreg_bank;

  localparam int W = 16;
  localparam int DEPTH = 6;
  localparam int AW = $clog2(DEPTH);
  localparam int NB = W / 8;

  logic             clk50m = 1'b0;
  logic             rst_n;
  logic             en;
  logic             load;
  logic             clr;
  logic [AW-1:0]    waddr;
  logic [W-1:0]     d;
  logic [NB-1:0]    be;
  logic [AW-1:0]    raddr_a;
  logic [AW-1:0]    raddr_b;
  logic [W-1:0]     qa;
  logic [W-1:0]     qb;
  logic [DEPTH-1:0] written;

  typedef struct {
    logic [W-1:0]     qa;
    logic [W-1:0]     qb;
    logic [DEPTH-1:0] wr;
  } exp_t;

  exp_t             exp_q[$];
  logic [W-1:0]     mem [DEPTH];
  logic [DEPTH-1:0] m_wr;
  logic [W-1:0]     m_qa;
  logic [W-1:0]     m_qb;
  int               checks = 0;
  int               errors = 0;

  dreg_bank #(.W(W), .DEPTH(DEPTH)) dut (
    .clk50m  (clk50m),
    .rst_n   (rst_n),
    .en      (en),
    .load    (load),
    .clr     (clr),
    .waddr   (waddr),
    .d       (d),
`ifdef DREG_BANK_BYTEMASK_EN
    .be      (be),
`endif
    .raddr_a (raddr_a),
    .raddr_b (raddr_b),
    .qa      (qa),
    .qb      (qb),
    .written (written)
  );

  initial forever #10 clk50m = ~clk50m;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int n = 0; n < DEPTH; n++) mem[n] = '0;
    m_wr = '0;
    m_qa = '0;
    m_qb = '0;
  endfunction

  // Write-first register file semantics applied to the inputs present at the edge
  task automatic model_step();
    logic [NB-1:0] m;
    exp_t          e;
`ifdef DREG_BANK_BYTEMASK_EN
    m = be;
`else
    m = '1;
`endif
    if (en) begin
      if (clr) begin
        model_reset();
      end else begin
        if (load && int'(waddr) < DEPTH) begin
          for (int i = 0; i < NB; i++)
            if (m[i]) mem[waddr][8*i +: 8] = d[8*i +: 8];
          m_wr[waddr] = 1'b1;
        end
        m_qa = (int'(raddr_a) < DEPTH) ? mem[raddr_a] : '0;
        m_qb = (int'(raddr_b) < DEPTH) ? mem[raddr_b] : '0;
      end
    end
    e.qa = m_qa;
    e.qb = m_qb;
    e.wr = m_wr;
    exp_q.push_back(e);
  endtask

  task automatic cycle(input logic e, input logic l, input logic c, input int wa,
                       input logic [W-1:0] wd, input logic [NB-1:0] wb, input int ra, input int rb);
    en      = e;
    load    = l;
    clr     = c;
    waddr   = AW'(wa);
    d       = wd;
    be      = wb;
    raddr_a = AW'(ra);
    raddr_b = AW'(rb);
    @(posedge clk50m);
    model_step();
    #2;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk50m);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("qa", 32'(qa), 32'(e.qa));
        check("qb", 32'(qb), 32'(e.qb));
        check("written", 32'(written), 32'(e.wr));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; en = 1'b1; load = 1'b1; clr = 1'b0; waddr = 3; d = 16'hFFFF;
    be = '1; raddr_a = 0; raddr_b = 1;
    model_reset();
    #70;
    check("reset_qa", 32'(qa), 32'h0);
    check("reset_qb", 32'(qb), 32'h0);
    check("reset_written", 32'(written), 32'h0);
    #5 rst_n = 1'b1;

    for (int i = 0; i < 8; i++) cycle(1, 0, 0, 0, 16'h0, '1, i, 7 - i);

    cycle(1, 1, 0, 3, 16'hAA55, '1, 0, 0);
    cycle(1, 1, 0, 5, 16'h1234, '1, 0, 0);
    cycle(1, 0, 0, 0, 16'h0, '1, 3, 5);

    cycle(1, 1, 0, 3, 16'h55AA, '1, 3, 3);
    cycle(0, 1, 0, 3, 16'h0000, '1, 5, 0);
    cycle(0, 0, 1, 0, 16'h0000, '1, 5, 0);
    cycle(1, 0, 0, 0, 16'h0, '1, 3, 5);

    cycle(1, 1, 1, 1, 16'hBEEF, '1, 3, 5);
    cycle(1, 0, 0, 0, 16'h0, '1, 1, 3);

    cycle(1, 1, 0, 2, 16'hFFFF, 2'b11, 0, 0);
    cycle(1, 1, 0, 2, 16'h0000, 2'b01, 2, 1);
    cycle(1, 1, 0, 1, 16'hC3C3, 2'b00, 2, 1);
    cycle(1, 0, 0, 0, 16'h0, '1, 2, 1);

    cycle(1, 1, 0, 7, 16'hABCD, '1, 7, 6);
    cycle(1, 0, 0, 0, 16'h0, '1, 7, 2);

    cycle(1, 1, 0, 4, 16'h1234, '1, 4, 2);
    @(negedge clk50m);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_qa", 32'(qa), 32'h0);
    check("async_rst_qb", 32'(qb), 32'h0);
    check("async_rst_written", 32'(written), 32'h0);
    model_reset();
    @(posedge clk50m);
    #5 rst_n = 1'b1;
    cycle(1, 0, 0, 0, 16'h0, '1, 4, 2);

    repeat (400) begin
      cycle(($urandom % 8) != 0, $urandom % 2, ($urandom % 32) == 0, $urandom % 8,
            W'($urandom), NB'($urandom), $urandom % 8, $urandom % 8);
    end

    repeat (3) @(negedge clk50m);
    check("scoreboard_drain", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
